// File: rtl/roi_trigger_sequencer_if.sv
// Stream bundle for the ROI trigger sequencer: energy samples in, ROI results out.
// The master side produces energy samples and consumes results.
interface roi_trigger_sequencer_if #(parameter int W = 8);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_e;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_roi;
    logic [W-1:0] out_emax;
    logic         out_trig;

    modport master (
        output in_valid, in_e, in_last, out_ready,
        input  in_ready, out_valid, out_roi, out_emax, out_trig
    );
    modport slave (
        input  in_valid, in_e, in_last, out_ready,
        output in_ready, out_valid, out_roi, out_emax, out_trig
    );
endinterface

// File: rtl/roi_trigger_sequencer.sv
// Event controller for the four-region ROI max encoder: collect E0..E3, pick the max,
// apply the threshold, hand off the result, then hold off for a dead time after a trigger.
module roi_trigger_sequencer #(
    parameter int W        = 8,
    parameter int DEADTIME = 4,
    parameter int DT_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    roi_trigger_sequencer_if.slave   bus,
    input  logic [W-1:0]             threshold,
    output logic                     busy,
    output logic                     frame_err
);
    typedef enum logic [1:0] {COLLECT, EVAL, OUT, DEAD} state_t;

    state_t          state, state_nxt;
    logic [1:0]      cnt;
    logic [W-1:0]    slot [4];
    logic [DT_W-1:0] dt_cnt;
    logic            accept, consume;
    logic [1:0]      roi;
    logic [W-1:0]    emax;

    assign accept  = bus.in_valid && (state == COLLECT);
    assign consume = bus.out_ready && (state == OUT);

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        roi  = 2'd0;
        emax = slot[0];
        for (int i = 1; i < 4; i++) begin
            if (slot[i] > emax) begin
                emax = slot[i];
                roi  = i[1:0];
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        case (state)
            COLLECT: begin
                bus.in_ready = 1'b1;
                if (accept && bus.in_last && cnt == 2'd3)
                    state_nxt = EVAL;
            end
            EVAL: state_nxt = OUT;
            OUT: begin
                bus.out_valid = 1'b1;
                if (consume)
                    state_nxt = (bus.out_trig && DEADTIME > 0) ? DEAD : COLLECT;
            end
            DEAD: begin
                busy = 1'b1;
                if (dt_cnt <= DT_W'(1))
                    state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= COLLECT;
            cnt          <= 2'd0;
            dt_cnt       <= '0;
            frame_err    <= 1'b0;
            bus.out_roi  <= 2'd0;
            bus.out_emax <= '0;
            bus.out_trig <= 1'b0;
            for (int i = 0; i < 4; i++) slot[i] <= '0;
        end else begin
            state     <= state_nxt;
            frame_err <= 1'b0;
            if (accept) begin
                slot[cnt] <= bus.in_e;
                if (bus.in_last || cnt == 2'd3) begin
                    // Either terminator mismatch drops the partial event.
                    cnt <= 2'd0;
                    if (!(bus.in_last && cnt == 2'd3))
                        frame_err <= 1'b1;
                end else begin
                    cnt <= cnt + 2'd1;
                end
            end
            if (state == EVAL) begin
                bus.out_roi  <= roi;
                bus.out_emax <= emax;
                bus.out_trig <= (emax >= threshold);
            end
            if (consume)
                dt_cnt <= DT_W'(DEADTIME);
            else if (state == DEAD)
                dt_cnt <= dt_cnt - DT_W'(1);
        end
    end
endmodule

// File: tb/tb_roi_trigger_sequencer.sv
// Directed bench for roi_trigger_sequencer with hand-computed expectations.
module tb_roi_trigger_sequencer;
    localparam int W = 8;
    localparam int DEADTIME = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] threshold;
    logic         busy, frame_err;
    int           n_cmp = 0;
    int           n_err = 0;

    roi_trigger_sequencer_if #(.W(W)) bus ();

    roi_trigger_sequencer #(.W(W), .DEADTIME(DEADTIME), .DT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .threshold (threshold),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] e, input logic last);
        bus.in_valid = 1'b1;
        bus.in_e     = e;
        bus.in_last  = last;
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic event4(input logic [W-1:0] a, b, c, d);
        send(a, 1'b0);
        send(b, 1'b0);
        send(c, 1'b0);
        send(d, 1'b1);
    endtask

    // Event with out_ready high: EVAL, then OUT, handshake, optional dead time.
    task automatic run_event(input string tag, input logic [W-1:0] a, b, c, d,
                             input logic [1:0] roi, input logic [W-1:0] emax, input logic trig);
        event4(a, b, c, d);
        chk({tag, "_eval_valid"}, 32'(bus.out_valid), 0);
        step();
        chk({tag, "_valid"}, 32'(bus.out_valid), 1);
        chk({tag, "_roi"}, 32'(bus.out_roi), 32'(roi));
        chk({tag, "_emax"}, 32'(bus.out_emax), 32'(emax));
        chk({tag, "_trig"}, 32'(bus.out_trig), 32'(trig));
        step();
        chk({tag, "_valid_drop"}, 32'(bus.out_valid), 0);
        if (trig) begin
            for (int i = 0; i < DEADTIME; i++) begin
                chk({tag, "_busy"}, 32'(busy), 1);
                chk({tag, "_dead_rdy"}, 32'(bus.in_ready), 0);
                step();
            end
        end
        chk({tag, "_busy_end"}, 32'(busy), 0);
        chk({tag, "_ready_back"}, 32'(bus.in_ready), 1);
    endtask

    initial begin
        rst = 1'b1;
        threshold = 8'd20;
        bus.in_valid = 1'b0;
        bus.in_e = '0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_roi", 32'(bus.out_roi), 0);
        chk("rst_emax", 32'(bus.out_emax), 0);
        chk("rst_trig", 32'(bus.out_trig), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_ready", 32'(bus.in_ready), 1);

        // 1: basic trigger with dead time
        run_event("t1", 8'd10, 8'd40, 8'd25, 8'd30, 2'd1, 8'd40, 1'b1);

        // 2: tie goes to lowest index; max in last slot; threshold 255 boundary
        run_event("t2a", 8'd50, 8'd50, 8'd50, 8'd50, 2'd0, 8'd50, 1'b1);
        threshold = 8'd255;
        run_event("t2b", 8'd0, 8'd0, 8'd0, 8'd255, 2'd3, 8'd255, 1'b1);
        threshold = 8'd0;
        run_event("zero", 8'd0, 8'd0, 8'd0, 8'd0, 2'd0, 8'd0, 1'b1);

        // 3: below threshold, no dead time
        threshold = 8'd9;
        run_event("t3", 8'd5, 8'd6, 8'd7, 8'd8, 2'd3, 8'd8, 1'b0);

        // 4: backpressure during OUT
        threshold = 8'd20;
        bus.out_ready = 1'b0;
        event4(8'd3, 8'd7, 8'd2, 8'd1);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t4_valid", 32'(bus.out_valid), 1);
            chk("t4_roi", 32'(bus.out_roi), 1);
            chk("t4_emax", 32'(bus.out_emax), 7);
            chk("t4_ready", 32'(bus.in_ready), 0);
            step();
        end
        bus.out_ready = 1'b1;
        chk("t4_trig", 32'(bus.out_trig), 0);
        step();
        chk("t4_valid_drop", 32'(bus.out_valid), 0);
        chk("t4_ready_back", 32'(bus.in_ready), 1);

        // 5: early in_last, then a clean event
        send(8'd11, 1'b0);
        send(8'd12, 1'b1);
        chk("t5_ferr", 32'(frame_err), 1);
        chk("t5_valid", 32'(bus.out_valid), 0);
        step();
        chk("t5_ferr_pulse", 32'(frame_err), 0);
        chk("t5_valid2", 32'(bus.out_valid), 0);
        threshold = 8'd5;
        run_event("t5", 8'd1, 8'd2, 8'd9, 8'd3, 2'd2, 8'd9, 1'b1);

        // missing in_last on the fourth sample
        send(8'd90, 1'b0);
        send(8'd91, 1'b0);
        send(8'd92, 1'b0);
        send(8'd93, 1'b0);
        chk("nolast_ferr", 32'(frame_err), 1);
        step();
        chk("nolast_valid", 32'(bus.out_valid), 0);
        chk("nolast_ready", 32'(bus.in_ready), 1);

        // 6: reset during OUT
        bus.out_ready = 1'b0;
        event4(8'd4, 8'd8, 8'd6, 8'd2);
        step();
        chk("t6_in_out", 32'(bus.out_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6o_valid", 32'(bus.out_valid), 0);
        chk("t6o_busy", 32'(busy), 0);
        chk("t6o_ready", 32'(bus.in_ready), 1);
        chk("t6o_emax", 32'(bus.out_emax), 0);

        // reset during DEAD
        bus.out_ready = 1'b1;
        event4(8'd4, 8'd8, 8'd6, 8'd2);
        step();
        step();
        chk("t6_in_dead", 32'(busy), 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6d_valid", 32'(bus.out_valid), 0);
        chk("t6d_busy", 32'(busy), 0);
        chk("t6d_ready", 32'(bus.in_ready), 1);
        threshold = 8'd100;
        run_event("t6f", 8'd12, 8'd34, 8'd56, 8'd21, 2'd2, 8'd56, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
